// File: rtl/box_field_sequencer_pkg.sv
// box_seq_pkg: box codes, sequencer states and LFSR helpers shared by the falling-box sequencer
package box_seq_pkg;
  typedef logic [2:0] box_code_t;
  typedef enum logic [1:0] {IDLE, RUN, SHIFT, OVER} seq_state_t;
  localparam box_code_t BOX_EMPTY = 3'd4;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic [7:0] lfsrStep(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction
  function automatic box_code_t boxCode(input logic [7:0] q);
    return q[2] ? BOX_EMPTY : {1'b0, q[1:0]};
  endfunction
  function automatic logic [7:0] satInc(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/box_field_sequencer_if.sv
// box_field_sequencer_if: button request handshake between the button front end and the sequencer
interface box_field_sequencer_if;
  logic btnValid;
  logic [1:0] btnLane;
  logic btnReady;
  modport master (output btnValid, output btnLane, input btnReady);
  modport slave (input btnValid, input btnLane, output btnReady);
endinterface

// File: rtl/box_field_sequencer_lfsr.sv
// box_lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with seed reload and step enable
module box_lfsr8
  import box_seq_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] q
);
  // reload takes priority over stepping so a game start always replays the same sequence
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) q <= SEED;
    else if (load) q <= SEED;
    else if (adv) q <= lfsrStep(q);
endmodule

// File: rtl/box_field_sequencer.sv
// box_field_sequencer: falling-box row state, scroll timing and button judging; BOX_SEQ_WRONG_PRESS_PENALTY_EN makes wrong presses cost a miss
module box_field_sequencer
  import box_seq_pkg::*;
#(
  parameter int         NUM_ROWS        = 5,
  parameter int         FRAMES_PER_STEP = 8,
  parameter int         MISS_LIMIT      = 8,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  start,
  input  logic                  frameDone,
  box_field_sequencer_if.slave  btn,
  output logic [3*NUM_ROWS-1:0] rowsOut,
  output logic [1:0]            boxCycle,
  output logic                  stepPulse,
  output logic [7:0]            score,
  output logic [7:0]            miss,
  output logic                  gameOver
);
  localparam int W = 3 * NUM_ROWS;
  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] LIMIT = 8'(MISS_LIMIT);
  localparam logic [W-1:0] ALL_EMPTY = {NUM_ROWS{BOX_EMPTY}};

  seq_state_t state, stateNext;
  logic [7:0] frameCnt, frameNext, scoreNext, missNext, lfsrQ;
  logic [W-1:0] rowsNext;
  logic [1:0] cycleNext;
  logic init, accept, hit, wrong, counting, stepDue, readyQ;
  box_code_t bottom;

  assign bottom = rowsOut[W-1 -: 3];
  assign accept = btn.btnValid & readyQ;
  assign hit = accept && bottom == {1'b0, btn.btnLane};
`ifdef BOX_SEQ_WRONG_PRESS_PENALTY_EN
  assign wrong = accept & ~hit;
`else
  assign wrong = 1'b0;
`endif
  assign counting = frameDone && (state == RUN || state == SHIFT);
  assign stepDue = counting && state == RUN && frameCnt == LAST_FRAME;
  assign btn.btnReady = readyQ;

  box_lfsr8 #(.SEED(LFSR_SEED)) lfsr (
    .CLK (CLK),
    .RSTn(RSTn),
    .load(init),
    .adv (state == SHIFT),
    .q   (lfsrQ)
  );

  // next state plus next game datapath; game-over wins over a pending scroll step
  always_comb begin
    stateNext = state;
    init = 1'b0;
    frameNext = counting ? (frameCnt == LAST_FRAME ? 8'd0 : frameCnt + 8'd1) : frameCnt;
    cycleNext = counting ? boxCycle + 2'd1 : boxCycle;
    scoreNext = hit ? satInc(score) : score;
    missNext = wrong ? satInc(miss) : miss;
    rowsNext = rowsOut;
    case (state)
      IDLE, OVER: begin
        init = start;
        stateNext = start ? RUN : state;
      end
      RUN: begin
        if (hit) rowsNext[W-1 -: 3] = BOX_EMPTY;
        stateNext = missNext >= LIMIT ? OVER : stepDue ? SHIFT : RUN;
      end
      SHIFT: begin
        missNext = bottom != BOX_EMPTY ? satInc(miss) : miss;
        rowsNext = {rowsOut[W-4:0], boxCode(lfsrQ)};
        stateNext = missNext >= LIMIT ? OVER : RUN;
      end
    endcase
    if (init) begin
      frameNext = 8'd0;
      cycleNext = 2'd0;
      scoreNext = 8'd0;
      missNext = 8'd0;
      rowsNext = ALL_EMPTY;
    end
  end

  // state register
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) state <= IDLE;
    else state <= stateNext;

  // registered game state and status flags, all derived from the upcoming state
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      rowsOut <= ALL_EMPTY;
      frameCnt <= 8'd0;
      boxCycle <= 2'd0;
      score <= 8'd0;
      miss <= 8'd0;
      readyQ <= 1'b0;
      stepPulse <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      rowsOut <= rowsNext;
      frameCnt <= frameNext;
      boxCycle <= cycleNext;
      score <= scoreNext;
      miss <= missNext;
      readyQ <= stateNext == RUN;
      stepPulse <= stateNext == SHIFT;
      gameOver <= stateNext == OVER;
    end
endmodule

// File: tb/tb_box_field_sequencer.sv
// tb_box_field_sequencer: self-checking bench with a cycle model scoreboard and a phase table
module tb_box_field_sequencer;
  localparam int NR = 5, FPS = 8, ML = 2;
`ifdef BOX_SEQ_WRONG_PRESS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_SHIFT = 2, M_OVER = 3;

  logic CLK = 1'b0, RSTn = 1'b0, start = 1'b0, frameDone = 1'b0;
  logic [3*NR-1:0] rowsOut;
  logic [1:0] boxCycle;
  logic stepPulse, gameOver;
  logic [7:0] score, miss;

  box_field_sequencer_if btnIf();

  box_field_sequencer #(
    .NUM_ROWS(NR), .FRAMES_PER_STEP(FPS), .MISS_LIMIT(ML), .LFSR_SEED(8'hA5)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .frameDone(frameDone), .btn(btnIf),
    .rowsOut(rowsOut), .boxCycle(boxCycle), .stepPulse(stepPulse),
    .score(score), .miss(miss), .gameOver(gameOver)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3*NR-1:0] rows;
    int score, miss, cyc;
    bit step, ready, over;
  } exp_t;

  typedef struct {
    string name;
    bit rst, st;
    int frames;
    bit press;
    bit [1:0] lane;
    int sc, mi, miPen;
    bit ov, ovPen;
  } phase_t;

  exp_t sb[$];
  phase_t tbl[$];
  int checks = 0, errors = 0;
  int mState, mScore, mMiss, mCycle, mFrame;
  int mRows[NR];
  logic [7:0] mLfsr;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic int sat(input int v);
    return v == 255 ? 255 : v + 1;
  endfunction

  task automatic modelInit();
    for (int i = 0; i < NR; i++) mRows[i] = 4;
    mLfsr = 8'hA5;
    mScore = 0; mMiss = 0; mCycle = 0; mFrame = 0;
  endtask

  task automatic modelStep(input bit s, input bit f, input bit v, input bit [1:0] l);
    int nState;
    bit due;
    if (!RSTn) begin
      modelInit();
      mState = M_IDLE;
      return;
    end
    nState = mState;
    due = 1'b0;
    if (f && (mState == M_RUN || mState == M_SHIFT)) begin
      mCycle = (mCycle + 1) % 4;
      if (mFrame == FPS - 1) begin
        mFrame = 0;
        due = mState == M_RUN;
      end else mFrame++;
    end
    case (mState)
      M_IDLE, M_OVER: if (s) begin modelInit(); nState = M_RUN; end
      M_RUN: begin
        if (v) begin
          if (mRows[NR-1] == int'(l)) begin mScore = sat(mScore); mRows[NR-1] = 4; end
          else if (PEN) mMiss = sat(mMiss);
        end
        nState = mMiss >= ML ? M_OVER : due ? M_SHIFT : M_RUN;
      end
      default: begin
        if (mRows[NR-1] != 4) mMiss = sat(mMiss);
        for (int i = NR - 1; i > 0; i--) mRows[i] = mRows[i-1];
        mRows[0] = mLfsr[2] ? 4 : int'(mLfsr[1:0]);
        mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
        nState = mMiss >= ML ? M_OVER : M_RUN;
      end
    endcase
    mState = nState;
  endtask

  task automatic tick(input bit s, input bit f, input bit v, input bit [1:0] l);
    exp_t e;
    start = s; frameDone = f; btnIf.btnValid = v; btnIf.btnLane = l;
    modelStep(s, f, v, l);
    for (int i = 0; i < NR; i++) e.rows[3*i +: 3] = 3'(mRows[i]);
    e.score = mScore; e.miss = mMiss; e.cyc = mCycle;
    e.step = mState == M_SHIFT; e.ready = mState == M_RUN; e.over = mState == M_OVER;
    sb.push_back(e);
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk("rowsOut", int'(rowsOut), int'(e.rows));
    chk("score", score, e.score);
    chk("miss", miss, e.miss);
    chk("boxCycle", boxCycle, e.cyc);
    chk("stepPulse", stepPulse, int'(e.step));
    chk("btnReady", btnIf.btnReady, int'(e.ready));
    chk("gameOver", gameOver, int'(e.over));
  endtask

  task automatic runStep();
    repeat (FPS) begin tick(0, 1, 0, 0); tick(0, 0, 0, 0); end
  endtask

  task automatic addPh(input string n, input bit r, input bit s, input int fr, input bit pr,
                       input bit [1:0] ln, input int sc, input int mi, input int miP,
                       input bit ov, input bit ovP);
    phase_t p;
    p.name = n; p.rst = r; p.st = s; p.frames = fr; p.press = pr; p.lane = ln;
    p.sc = sc; p.mi = mi; p.miPen = miP; p.ov = ov; p.ovPen = ovP;
    tbl.push_back(p);
  endtask

  initial begin
    int stepAt, stepCnt, idx;
    addPh("rst_start", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) addPh($sformatf("step%0d", i), 0, 0, FPS, 0, 0, 0, 0, 0, 0, 0);
    addPh("step6_hit2", 0, 0, FPS, 1, 2, 1, 0, 0, 0, 0);
    addPh("step7", 0, 0, FPS, 0, 0, 1, 0, 0, 0, 0);
    addPh("step8_hit2", 0, 0, FPS, 1, 2, 2, 0, 0, 0, 0);
    addPh("step9", 0, 0, FPS, 0, 0, 2, 0, 0, 0, 0);
    addPh("step10_hit1", 0, 0, FPS, 1, 1, 3, 0, 0, 0, 0);
    addPh("step11_wrong1", 0, 0, FPS, 1, 1, 3, 0, 1, 0, 0);
    addPh("step12_fall", 0, 0, FPS, 0, 0, 3, 1, 2, 0, 1);
    addPh("rst_start2", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) addPh($sformatf("idle_step%0d", i), 0, 0, FPS, 0, 0, 0, 0, 0, 0, 0);
    addPh("fall_s7", 0, 0, FPS, 0, 0, 0, 1, 1, 0, 0);
    addPh("s8", 0, 0, FPS, 0, 0, 0, 1, 1, 0, 0);
    addPh("s9_over", 0, 0, FPS, 0, 0, 0, 2, 2, 1, 1);
    addPh("frozen", 0, 0, FPS, 1, 2, 0, 2, 2, 1, 1);
    addPh("restart", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    addPh("after_restart", 0, 0, FPS, 0, 0, 0, 0, 0, 0, 0);

    btnIf.btnValid = 1'b0; btnIf.btnLane = 2'd0;
    modelInit(); mState = M_IDLE;
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    RSTn = 1'b1;
    tick(0, 0, 1, 2);
    tick(1, 0, 0, 0);

    stepCnt = 0; stepAt = -1; idx = 0;
    for (int i = 0; i < FPS; i++) begin
      tick(0, 1, 0, 0);
      if (stepPulse) begin stepCnt++; stepAt = idx; end
      idx++;
      tick(0, 0, 0, 0);
      if (stepPulse) begin stepCnt++; stepAt = idx; end
      idx++;
    end
    chk("step_count", stepCnt, 1);
    chk("step_at", stepAt, 2 * FPS - 2);
    chk("row0_seed", int'(rowsOut[2:0]), 4);
    chk("cycle_after_8", boxCycle, 0);

    repeat (5) runStep();
    repeat (FPS - 1) begin tick(0, 1, 0, 0); tick(0, 0, 0, 0); end
    tick(0, 1, 0, 0);
    chk("ready_in_shift", btnIf.btnReady, 0);
    tick(0, 0, 1, 2);
    chk("hold_shift7_score", score, 0);
    chk("hold_shift7_miss", miss, 1);
    tick(0, 0, 0, 0);
    repeat (FPS - 1) begin tick(0, 1, 0, 0); tick(0, 0, 0, 0); end
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 2);
    chk("hold_shift8_score", score, 0);
    tick(0, 0, 1, 2);
    chk("accept_after_shift", score, 1);
    chk("bottom_cleared", int'(rowsOut[3*NR-1 -: 3]), 4);
    tick(0, 0, 0, 0);

    repeat (3) begin tick(0, 1, 0, 0); tick(0, 0, 0, 0); end
    RSTn = 1'b0;
    #2;
    chk("async_rows", int'(rowsOut), int'(15'b100_100_100_100_100));
    chk("async_score", score, 0);
    chk("async_miss", miss, 0);
    chk("async_ready", btnIf.btnReady, 0);
    chk("async_cycle", boxCycle, 0);
    chk("async_over", gameOver, 0);
    modelInit(); mState = M_IDLE;
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    RSTn = 1'b1;

    foreach (tbl[k]) begin
      if (tbl[k].rst) begin RSTn = 1'b0; tick(0, 0, 0, 0); RSTn = 1'b1; end
      if (tbl[k].st) tick(1, 0, 0, 0);
      for (int j = 0; j < tbl[k].frames; j++) begin tick(0, 1, 0, 0); tick(0, 0, 0, 0); end
      if (tbl[k].press) tick(0, 0, 1, tbl[k].lane);
      tick(0, 0, 0, 0);
      chk({tbl[k].name, "_score"}, score, tbl[k].sc);
      chk({tbl[k].name, "_miss"}, miss, PEN ? tbl[k].miPen : tbl[k].mi);
      chk({tbl[k].name, "_over"}, gameOver, int'(PEN ? tbl[k].ovPen : tbl[k].ov));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/box_field_sequencer.md
# box_field_sequencer

Sequencer for the falling-box LED matrix game. It owns the box-row state that the matrix scan driver renders, and steps that state down one row every `FRAMES_PER_STEP` display frames. New boxes are spawned at the top row from an LFSR. Player button presses are judged against the bottom row and counted as score and misses. It sits between the button front end and the scan driver, and also supplies the scan driver's `boxCycle` phase.

## Interface
Parameters:
- `NUM_ROWS`, 5: number of box rows; row 0 is the top, row `NUM_ROWS-1` is the bottom.
- `FRAMES_PER_STEP`, 8: `frameDone` pulses per scroll step; legal range 1..255.
- `MISS_LIMIT`, 8: miss count that ends the game; legal range 1..255.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `CLK`, in, 1: clock.
- `RSTn`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: level; starts or restarts the game from IDLE or OVER.
- `frameDone`, in, 1: one-cycle pulse from the scan driver at frame wrap (y 0→15).
- `btnValid`, in, 1: button request valid.
- `btnLane`, in, 2: lane pressed, 0..3.
- `btnReady`, out, 1: button accept.
- `rowsOut`, out, 3×`NUM_ROWS`: packed 3-bit row codes, row i at bits [3i+2:3i]. Codes 0..3 are a lane; 4 is empty.
- `boxCycle`, out, 2: scan phase for the driver.
- `stepPulse`, out, 1: one-cycle pulse when a scroll step is applied.
- `score`, out, 8: hits, saturating at 255.
- `miss`, out, 8: misses, saturating at 255.
- `gameOver`, out, 1: high in OVER.

## Operation
States are IDLE, RUN, SHIFT and OVER.

Reset / initialization (async reset, and every game start):
- All rows = 4 (empty); LFSR = `LFSR_SEED`.
- `score`, `miss`, `boxCycle` and the frame counter = 0.
- `btnReady`, `stepPulse` and `gameOver` = 0.
- Async reset puts the block in IDLE.

Transitions:
- IDLE: `start`=1 → RUN, applying the initialization above.
- RUN: on a `frameDone` pulse, `boxCycle` increments mod 4. The frame counter increments; when it equals `FRAMES_PER_STEP-1`, the counter clears and the next state is SHIFT.
- SHIFT (exactly one cycle) performs the scroll step:
  - If the bottom row is not empty, `miss` increments (the box was missed).
  - row[i] takes row[i-1] for i≥1.
  - row[0] is loaded from the pre-advance LFSR value: empty if lfsr[2]=1, otherwise lane lfsr[1:0].
  - The LFSR then advances one step.
  - `stepPulse`=1 for this cycle.
  - Next state is OVER if the post-update `miss` ≥ `MISS_LIMIT`, else RUN.
- OVER: `gameOver`=1, all state frozen, `btnReady`=0. `start`=1 → re-initialize and go to RUN.

Frame counting in SHIFT: `frameDone` is still counted (it increments `boxCycle` and the frame counter).

Buttons:
- `btnReady` = 1 only in RUN.
- A press is accepted when `btnValid` & `btnReady`.
- If the bottom row equals `btnLane`, it is a hit: `score` increments and the bottom row is set to 4 that cycle.
- Otherwise, see Configuration.
- A hit that completes in the cycle before SHIFT clears the row, so SHIFT sees it empty and counts no miss.

Arithmetic and LFSR:
- The LFSR is an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left with the feedback into bit 0.
- Counters saturate and never wrap.
- The game-over check also runs after a penalty miss in RUN: `miss` ≥ `MISS_LIMIT` → OVER on the next cycle.

## Timing
- All outputs are registered.
- `rowsOut` reflects a SHIFT or a hit on the cycle after the triggering edge.
- Scroll latency is the `FRAMES_PER_STEP`-th `frameDone` counted since RUN entry or the previous SHIFT entry, +1 cycle.
- Button handshake: the press is consumed in the cycle where valid&ready are both high. `btnValid` may be held indefinitely while ready is low (SHIFT, IDLE, OVER).
- Reset mid-game takes effect immediately (asynchronous); all outputs return to their reset values.

## Configuration
- `BOX_SEQ_WRONG_PRESS_PENALTY_EN` defined: an accepted press on the wrong lane, or while the bottom row is empty, increments `miss` by 1.
- Undefined: such presses are accepted and ignored; no counter changes.

## Structure
- Package `box_seq_pkg` holds:
  - `BOX_EMPTY` = 3'd4;
  - the `box_code_t` 3-bit typedef;
  - the `seq_state_t` enum {IDLE, RUN, SHIFT, OVER};
  - the LFSR tap mask constant.
- Sub-module `box_lfsr8`: 8-bit LFSR with seed parameter, load, advance enable and `q` output. It is used once.

## Test plan
Unless stated, use defaults.
- **Reset:** assert `RSTn`=0 mid-RUN → `rowsOut`=15'b100_100_100_100_100, `score`=0, `miss`=0, state IDLE, `btnReady`=0.
- **Scroll timing:** with `FRAMES_PER_STEP`=8, `start` then 8 `frameDone` pulses → exactly one `stepPulse`, one cycle after the 8th pulse. row0 = code from seed A5 (bit2=1 → empty). `boxCycle`=0 after 8 pulses.
- **Hit:** force the bottom row = 2 via scroll, press lane 2 → `score`=1, bottom row = 4; the next SHIFT does not increment `miss`.
- **Miss to game over:** `MISS_LIMIT`=2, let two non-empty boxes fall off the bottom with no presses → `miss`=2, `gameOver`=1, `btnReady`=0; `start` → `miss`=0, RUN.
- **Handshake:** hold `btnValid`=1 across a SHIFT cycle → press not accepted in SHIFT, accepted on the first RUN cycle after.
- **Wrong press:** lane 1 pressed against bottom row 3 → `miss`+1 with `BOX_SEQ_WRONG_PRESS_PENALTY_EN`, unchanged without it.
